decoder2_4_stream: RTL



---
 rtl/decoder2_4_stream.sv | 101 ++++++++++
 1 files changed

// File: rtl/decoder2_4_stream.sv
// decoder2_4_stream: skid-buffered 2-to-4 one-hot decoder with saturating per-line hit counters (optional DEC_PARITY_EN).
module decoder2_4_stream #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             a,
  input  logic             b,
  input  logic             en,
`ifdef DEC_PARITY_EN
  input  logic             p,
  output logic             err,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic             d0,
  output logic             d1,
  output logic             d2,
  output logic             d3,
  input  logic [1:0]       cnt_sel,
  output logic [CNT_W-1:0] cnt_out,
  input  logic             cnt_clr
);
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_skid_valid;
  logic [3:0]       r_out_d;
  logic [3:0]       r_skid_d;
  logic [CNT_W-1:0] r_cnt [4];
  logic             w_in_xfer;
  logic             w_out_xfer;
  logic             w_tok_ok;
  logic             w_load_out;
  logic [3:0]       w_new_d;
  logic             w_nxt_out_valid;
  logic [3:0]       w_nxt_out_d;
  logic             w_nxt_skid_valid;
  logic [3:0]       w_nxt_skid_d;

  always_comb begin
    w_in_xfer        = in_valid & r_in_ready;
    w_out_xfer       = r_out_valid & out_ready;
`ifdef DEC_PARITY_EN
    w_tok_ok         = en & ~(a ^ b ^ en ^ p);
`else
    w_tok_ok         = en;
`endif
    w_new_d          = w_tok_ok ? 4'b0001 << {a, b} : 4'b0000;
    // head register is free when empty or being drained; skid always feeds it first
    w_load_out       = ~r_out_valid | w_out_xfer;
    w_nxt_out_valid  = w_load_out ? (r_skid_valid | w_in_xfer) : 1'b1;
    w_nxt_out_d      = ~w_load_out ? r_out_d : r_skid_valid ? r_skid_d : w_in_xfer ? w_new_d : 4'b0000;
    w_nxt_skid_valid = w_load_out ? 1'b0 : (r_skid_valid | w_in_xfer);
    w_nxt_skid_d     = (~w_load_out & ~r_skid_valid & w_in_xfer) ? w_new_d : r_skid_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_in_ready   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_out_d      <= 4'b0000;
      r_skid_d     <= 4'b0000;
    end else begin
      r_in_ready   <= ~(w_nxt_out_valid & w_nxt_skid_valid);
      r_out_valid  <= w_nxt_out_valid;
      r_skid_valid <= w_nxt_skid_valid;
      r_out_d      <= w_nxt_out_d;
      r_skid_d     <= w_nxt_skid_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!rst_n || cnt_clr)
        r_cnt[i] <= '0;
      else if (w_out_xfer && r_out_d[i] && r_cnt[i] != {CNT_W{1'b1}})
        r_cnt[i] <= r_cnt[i] + 1'b1;
    end
  end

`ifdef DEC_PARITY_EN
  logic r_err;

  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr)
      r_err <= 1'b0;
    else if (w_in_xfer && (a ^ b ^ en ^ p))
      r_err <= 1'b1;
  end

  assign err = r_err;
`endif

  assign in_ready         = r_in_ready;
  assign out_valid        = r_out_valid;
  assign {d3, d2, d1, d0} = r_out_d;
  assign cnt_out          = r_cnt[cnt_sel];
endmodule
